// File: rtl/ctrl_pipe_hazard_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_hazard_pkg
//   Definitions shared by the decoder and the control pipeline.
//   - ALUOp encodings driven by the decoder on id_alu_op.
//   - ctrl_t: the decoded control bundle. Its packed field order fixes the
//     bit positions when the bundle is stored in a pipeline register.
//     reg_write is bit 0 and alu_op occupies the two MSBs.
//   - CTRL_W: the bundle width. CTRL_BUBBLE: the all-inactive bundle.
// ----------------------------------------------------------------------------
package ctrl_pipe_hazard_pkg;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_R_TYPE = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_2_reg;
        logic       reg_write;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    localparam ctrl_t CTRL_BUBBLE = '{alu_op: ALU_ADD, default: 1'b0};

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_hazard_if
//   Decoder-to-pipeline control bus. It carries one decoded instruction from
//   the ID stage.
//   master : decoder side, which drives every signal.
//   slave  : control pipeline side, which samples every signal.
//   Signals:
//     id_valid      ID holds a real instruction (0 = bubble)
//     id_alu_op     ALUOp (see ctrl_pipe_hazard_pkg)
//     id_alu_src, id_branch, id_jump, id_mem_read, id_mem_write,
//     id_mem_2_reg, id_reg_write   single-bit decoded controls
//     id_rs1, id_rs2  source register indices
//     id_rd           destination register index
// ----------------------------------------------------------------------------
interface ctrl_pipe_hazard_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [1:0]            id_alu_op;
    logic                  id_alu_src;
    logic                  id_branch;
    logic                  id_jump;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_mem_2_reg;
    logic                  id_reg_write;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;

    modport master (
        output id_valid, id_alu_op, id_alu_src, id_branch, id_jump,
               id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write,
               id_rs1, id_rs2, id_rd
    );

    modport slave (
        input  id_valid, id_alu_op, id_alu_src, id_branch, id_jump,
               id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write,
               id_rs1, id_rs2, id_rd
    );
endinterface

// File: rtl/ctrl_pipe_hazard_stage_reg.sv
// ----------------------------------------------------------------------------
// ctrl_stage_reg
//   A single pipeline register for a control bundle.
//   An all-zero word is a bubble: every control is inactive and rd is 0.
//   Ports:
//     clk     core clock (rising edge)
//     arst_n  asynchronous reset, active low. Reset loads a bubble.
//     en      capture d at the next edge
//     bubble  synchronous bubble insert. It overrides en.
//     d, q    W-bit stage input and registered output
// ----------------------------------------------------------------------------
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: state is updated with non-blocking assignments only, so every
    // stage samples its neighbour's pre-edge value and the pipe shifts by
    // exactly one stage per clock.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_hazard
//   Control pipeline that receives the decoder's bundles. It carries the
//   controls through ID/EX, EX/MEM and MEM/WB, detects load-use hazards, and
//   handles taken branch/jump redirects.
//   Ports:
//     clk, arst_n     clock and asynchronous active-low reset
//     id_bus          decoded ID-stage bundle (slave side)
//     ex_redirect     EX resolved a taken branch or jump this cycle
//     pc_write        0 freezes the PC             (combinational)
//     if_id_write     0 freezes IF/ID              (combinational)
//     if_id_flush     1 clears IF/ID at next edge  (combinational)
//     ex_*            EX-stage controls and destination   (registered)
//     mem_*           MEM-stage controls and destination  (registered)
//     wb_*            WB-stage controls and destination   (registered)
//     stall_cnt       load-use stall cycles since reset; wraps
//     flush_cnt       redirect flushes since reset; wraps
// ----------------------------------------------------------------------------
module ctrl_pipe_hazard
    import ctrl_pipe_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    ctrl_pipe_hazard_if.slave     id_bus,
    input  logic                  ex_redirect,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_mem_2_reg,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int ID_EX_W  = CTRL_W + REG_ADDR_W;
    localparam int EX_MEM_W = 4 + REG_ADDR_W;
    localparam int MEM_WB_W = 2 + REG_ADDR_W;

    ctrl_t                 id_ctrl;
    ctrl_t                 ex_ctrl;
    logic [ID_EX_W-1:0]    id_ex_d;
    logic [ID_EX_W-1:0]    id_ex_q;
    logic [EX_MEM_W-1:0]   ex_mem_d;
    logic [EX_MEM_W-1:0]   ex_mem_q;
    logic [MEM_WB_W-1:0]   mem_wb_d;
    logic [MEM_WB_W-1:0]   mem_wb_q;
    logic                  mem_mem_2_reg;
    logic                  hz;
    logic                  stall;
    logic                  id_ex_bubble;

    assign id_ctrl = '{
        alu_op:    id_bus.id_alu_op,
        alu_src:   id_bus.id_alu_src,
        branch:    id_bus.id_branch,
        jump:      id_bus.id_jump,
        mem_read:  id_bus.id_mem_read,
        mem_write: id_bus.id_mem_write,
        mem_2_reg: id_bus.id_mem_2_reg,
        reg_write: id_bus.id_reg_write
    };

    // The load in EX has not produced its data yet. An ID instruction that
    // reads that register must wait one cycle. Register 0 is never a real
    // dependency.
    assign hz = ex_ctrl.mem_read
              & (ex_rd != '0)
              & ((ex_rd == id_bus.id_rs1) | (ex_rd == id_bus.id_rs2))
              & id_bus.id_valid;

    // The redirect discards the ID instruction, so a hazard on that
    // instruction is moot. The redirect wins over the stall.
    assign stall        = hz & ~ex_redirect;
    assign id_ex_bubble = ~id_bus.id_valid | stall | ex_redirect;

    // NOTE: the hazard controls are continuous assignments from the current
    // state and inputs. Registering them would freeze the PC one cycle too
    // late.
    assign pc_write    = ~stall;
    assign if_id_write = ~stall;
    assign if_id_flush = ex_redirect;

    // ID/EX
    assign id_ex_d = {id_ctrl, id_bus.id_rd};

    ctrl_stage_reg #(.W(ID_EX_W)) u_id_ex (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (1'b1),
        .bubble (id_ex_bubble),
        .d      (id_ex_d),
        .q      (id_ex_q)
    );

    assign {ex_ctrl, ex_rd} = id_ex_q;
    assign ex_alu_op  = ex_ctrl.alu_op;
    assign ex_alu_src = ex_ctrl.alu_src;
    assign ex_branch  = ex_ctrl.branch;
    assign ex_jump    = ex_ctrl.jump;

    // EX/MEM: only the controls still needed downstream are carried. The
    // redirecting instruction itself moves on normally.
    assign ex_mem_d = {ex_ctrl.mem_read, ex_ctrl.mem_write,
                       ex_ctrl.mem_2_reg, ex_ctrl.reg_write, ex_rd};

    ctrl_stage_reg #(.W(EX_MEM_W)) u_ex_mem (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (1'b1),
        .bubble (1'b0),
        .d      (ex_mem_d),
        .q      (ex_mem_q)
    );

    assign {mem_mem_read, mem_mem_write, mem_mem_2_reg,
            mem_reg_write, mem_rd} = ex_mem_q;

    // MEM/WB
    assign mem_wb_d = {mem_mem_2_reg, mem_reg_write, mem_rd};

    ctrl_stage_reg #(.W(MEM_WB_W)) u_mem_wb (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (1'b1),
        .bubble (1'b0),
        .d      (mem_wb_d),
        .q      (mem_wb_q)
    );

    assign {wb_mem_2_reg, wb_reg_write, wb_rd} = mem_wb_q;

    // Event counters. They wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ex_redirect) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
